// File: rtl/bbw_stage_sequencer.sv
`default_nettype none
// ============================================================================
// bbw_stage_sequencer - big-bad-wolf game flow and blow-progress integrator.
// Optional macro BBW_TIMEOUT_EN adds a per-stage timeout and a LOSE screen.
// Revision: 1.0
// ============================================================================
module bbw_stage_sequencer #(
  parameter int PROG_MAX    = 72,
  parameter int STRAW_GAIN  = 6,
  parameter int STICK_GAIN  = 4,
  parameter int BRICK_GAIN  = 2,
  parameter int GRAVITY     = 1,
  parameter int VOL_THRESH  = 1,
  parameter int STAGE_DELAY = 50
`ifdef BBW_TIMEOUT_EN
  ,
  parameter int STAGE_TIMEOUT = 750
`endif
) (
  input  logic       clock_6pt25mhz,
  input  logic       game_reset_n,
  input  logic       tick_25hz,
  input  logic       enable_bbw,
  input  logic       buttonU,
  input  logic [3:0] volume,
  output logic [2:0] screen_state,
  output logic [7:0] progress,
  output logic       show_wind,
  output logic       show_blow,
  output logic       stage_done,
  output logic       game_won
`ifdef BBW_TIMEOUT_EN
  ,
  output logic       game_lost
`endif
);

  typedef enum logic [2:0] {
    ST_INSTR = 3'd0,
    ST_STRAW = 3'd1,
    ST_STICK = 3'd2,
    ST_BRICK = 3'd3,
    ST_WIN   = 3'd4,
    ST_TRANS = 3'd5,
    ST_LOSE  = 3'd6
  } state_t;

  localparam int DW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;

  localparam logic [7:0]    C_PROG_MAX   = 8'(PROG_MAX);
  localparam logic [7:0]    C_GRAVITY    = 8'(GRAVITY);
  localparam logic [3:0]    C_VOL_THRESH = 4'(VOL_THRESH);
  localparam logic [DW-1:0] C_DELAY_LAST = DW'(STAGE_DELAY - 1);

`ifdef BBW_TIMEOUT_EN
  localparam int TW = $clog2(STAGE_TIMEOUT + 1);
  localparam logic [TW-1:0] C_TIMEOUT_LAST = TW'(STAGE_TIMEOUT - 1);
`endif

  state_t        r_state, w_state_nxt;
  state_t        r_next_stage, w_next_stage_nxt;
  logic [DW-1:0] r_delay, w_delay_nxt;
  logic [7:0]    r_progress, w_progress_nxt;
  logic          r_show_wind, w_show_wind_nxt;
  logic          r_show_blow, w_show_blow_nxt;
  logic          r_stage_done, w_stage_done_nxt;
  logic          r_btn_prev;

`ifdef BBW_TIMEOUT_EN
  logic [TW-1:0] r_stage_ticks, w_stage_ticks_nxt;
  logic          w_expire;
`endif

  logic       w_advance;
  logic       w_btn_edge;
  logic       w_loud;
  logic [7:0] w_gain;
  logic [8:0] w_sum;
  logic [7:0] w_prog_rise;
  logic [7:0] w_prog_fall;
  logic [7:0] w_prog_play;

  assign w_advance  = tick_25hz & enable_bbw;
  assign w_btn_edge = buttonU & ~r_btn_prev;
  assign w_loud     = (volume >= C_VOL_THRESH);

  always_comb begin
    w_gain = 8'd0;
    case (r_state)
      ST_STRAW: w_gain = 8'(STRAW_GAIN);
      ST_STICK: w_gain = 8'(STICK_GAIN);
      ST_BRICK: w_gain = 8'(BRICK_GAIN);
      default:  w_gain = 8'd0;
    endcase
  end

  // Nine-bit sum so saturation at PROG_MAX can never be defeated by a wrap.
  assign w_sum       = {1'b0, r_progress} + {1'b0, w_gain};
  assign w_prog_rise = (w_sum >= {1'b0, C_PROG_MAX}) ? C_PROG_MAX : w_sum[7:0];
  assign w_prog_fall = (r_progress > C_GRAVITY) ? (r_progress - C_GRAVITY) : 8'd0;
  assign w_prog_play = w_loud ? w_prog_rise : w_prog_fall;

`ifdef BBW_TIMEOUT_EN
  assign w_expire = (r_stage_ticks == C_TIMEOUT_LAST);
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_next_stage_nxt = r_next_stage;
    w_delay_nxt      = r_delay;
    w_progress_nxt   = r_progress;
    w_show_wind_nxt  = 1'b0;
    w_show_blow_nxt  = 1'b0;
    w_stage_done_nxt = 1'b0;
`ifdef BBW_TIMEOUT_EN
    w_stage_ticks_nxt = r_stage_ticks;
`endif

    case (r_state)
      ST_INSTR: begin
        if (w_btn_edge) begin
          w_state_nxt    = ST_STRAW;
          w_progress_nxt = 8'd0;
`ifdef BBW_TIMEOUT_EN
          w_stage_ticks_nxt = '0;
`endif
        end
      end

      ST_STRAW, ST_STICK, ST_BRICK: begin
        w_progress_nxt = w_prog_play;
`ifdef BBW_TIMEOUT_EN
        w_stage_ticks_nxt = r_stage_ticks + TW'(1);
`endif
        if (w_prog_play == C_PROG_MAX) begin
          w_state_nxt      = ST_TRANS;
          w_delay_nxt      = C_DELAY_LAST;
          w_stage_done_nxt = 1'b1;
          case (r_state)
            ST_STRAW: w_next_stage_nxt = ST_STICK;
            ST_STICK: w_next_stage_nxt = ST_BRICK;
            default:  w_next_stage_nxt = ST_WIN;
          endcase
`ifdef BBW_TIMEOUT_EN
        end else if (w_expire) begin
          w_state_nxt = ST_LOSE;
`endif
        end else begin
          w_show_wind_nxt = w_loud;
          w_show_blow_nxt = ~w_loud;
        end
      end

      ST_TRANS: begin
        if (r_delay == '0) begin
          w_state_nxt    = r_next_stage;
          w_progress_nxt = 8'd0;
`ifdef BBW_TIMEOUT_EN
          w_stage_ticks_nxt = '0;
`endif
        end else begin
          w_delay_nxt = r_delay - DW'(1);
        end
      end

      ST_WIN: begin
        if (w_btn_edge) begin
          w_state_nxt      = ST_INSTR;
          w_progress_nxt   = 8'd0;
          w_next_stage_nxt = ST_STICK;
        end
      end

`ifdef BBW_TIMEOUT_EN
      ST_LOSE: begin
        if (w_btn_edge) begin
          w_state_nxt      = ST_INSTR;
          w_progress_nxt   = 8'd0;
          w_next_stage_nxt = ST_STICK;
        end
      end
`endif

      default: begin
        w_state_nxt    = ST_INSTR;
        w_progress_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock_6pt25mhz or negedge game_reset_n) begin
    if (!game_reset_n) begin
      r_state      <= ST_INSTR;
      r_next_stage <= ST_STICK;
      r_delay      <= '0;
      r_progress   <= 8'd0;
      r_show_wind  <= 1'b0;
      r_show_blow  <= 1'b0;
      r_stage_done <= 1'b0;
      r_btn_prev   <= 1'b1;
`ifdef BBW_TIMEOUT_EN
      r_stage_ticks <= '0;
`endif
    end else begin
      // stage_done is a single-clock pulse; everything else freezes off-tick.
      r_stage_done <= w_advance & w_stage_done_nxt;
      if (w_advance) begin
        r_state      <= w_state_nxt;
        r_next_stage <= w_next_stage_nxt;
        r_delay      <= w_delay_nxt;
        r_progress   <= w_progress_nxt;
        r_show_wind  <= w_show_wind_nxt;
        r_show_blow  <= w_show_blow_nxt;
        r_btn_prev   <= buttonU;
`ifdef BBW_TIMEOUT_EN
        r_stage_ticks <= w_stage_ticks_nxt;
`endif
      end
    end
  end

  assign screen_state = r_state;
  assign progress     = r_progress;
  assign show_wind    = r_show_wind;
  assign show_blow    = r_show_blow;
  assign stage_done   = r_stage_done;
  assign game_won     = (r_state == ST_WIN);
`ifdef BBW_TIMEOUT_EN
  assign game_lost    = (r_state == ST_LOSE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_bbw_stage_sequencer.sv
`default_nettype none
// ============================================================================
// tb_bbw_stage_sequencer - directed checks of game flow, progress and flags.
// Revision: 1.0
// ============================================================================
module tb_bbw_stage_sequencer;

  logic       clock_6pt25mhz = 1'b0;
  logic       game_reset_n   = 1'b0;
  logic       tick_25hz      = 1'b0;
  logic       enable_bbw     = 1'b1;
  logic       buttonU        = 1'b1;
  logic [3:0] volume         = 4'd0;
  logic [2:0] screen_state;
  logic [7:0] progress;
  logic       show_wind;
  logic       show_blow;
  logic       stage_done;
  logic       game_won;
`ifdef BBW_TIMEOUT_EN
  logic       game_lost;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock_6pt25mhz = ~clock_6pt25mhz;

  bbw_stage_sequencer dut (
    .clock_6pt25mhz (clock_6pt25mhz),
    .game_reset_n   (game_reset_n),
    .tick_25hz      (tick_25hz),
    .enable_bbw     (enable_bbw),
    .buttonU        (buttonU),
    .volume         (volume),
    .screen_state   (screen_state),
    .progress       (progress),
    .show_wind      (show_wind),
    .show_blow      (show_blow),
    .stage_done     (stage_done),
    .game_won       (game_won)
`ifdef BBW_TIMEOUT_EN
    ,
    .game_lost      (game_lost)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One tick strobe; returns 1 time unit after the edge that consumed it.
  task automatic tick1();
    tick_25hz = 1'b1;
    @(posedge clock_6pt25mhz);
    #1;
    tick_25hz = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock_6pt25mhz);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick1();
      idle(1);
    end
  endtask

  task automatic do_reset();
    game_reset_n = 1'b0;
    idle(1);
    game_reset_n = 1'b1;
  endtask

  task automatic start_game();
    buttonU = 1'b0;
    ticks(1);
    buttonU = 1'b1;
    ticks(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with the button pressed.
    #12;
    check("rst_state", int'(screen_state), 0);
    check("rst_progress", int'(progress), 0);
    check("rst_wind", int'(show_wind), 0);
    check("rst_blow", int'(show_blow), 0);
    check("rst_done", int'(stage_done), 0);
    check("rst_won", int'(game_won), 0);
    game_reset_n = 1'b1;
    ticks(3);
    check("held_btn_no_start", int'(screen_state), 0);

    // Start, then fill straw at gain 6.
    buttonU = 1'b0;
    ticks(1);
    check("btn_low_instr", int'(screen_state), 0);
    buttonU = 1'b1;
    ticks(1);
    check("start_straw", int'(screen_state), 1);
    check("start_progress", int'(progress), 0);
    buttonU = 1'b0;
    volume  = 4'd5;
    for (int k = 1; k <= 12; k++) begin
      tick1();
      check("straw_fill", int'(progress), 6 * k);
      if (k < 12) begin
        check("straw_state", int'(screen_state), 1);
        check("straw_wind", int'(show_wind), 1);
        check("straw_done_low", int'(stage_done), 0);
        idle(1);
      end
    end
    check("straw_trans", int'(screen_state), 5);
    check("straw_done_pulse", int'(stage_done), 1);
    check("trans_wind", int'(show_wind), 0);
    idle(1);
    check("done_one_clock", int'(stage_done), 0);

    // Full run at volume 15.
    volume = 4'd15;
    ticks(49);
    check("trans_hold", int'(screen_state), 5);
    check("trans_prog_max", int'(progress), 72);
    ticks(1);
    check("stick_entry", int'(screen_state), 2);
    check("stick_entry_prog", int'(progress), 0);
    ticks(17);
    check("stick_68", int'(progress), 68);
    check("stick_state", int'(screen_state), 2);
    ticks(1);
    check("stick_72", int'(progress), 72);
    check("stick_trans", int'(screen_state), 5);
    buttonU = 1'b1;
    ticks(49);
    check("btn_ignored_trans", int'(screen_state), 5);
    ticks(1);
    check("brick_entry", int'(screen_state), 3);
    buttonU = 1'b0;
    ticks(35);
    check("brick_70", int'(progress), 70);
    ticks(1);
    check("brick_72", int'(progress), 72);
    check("brick_trans", int'(screen_state), 5);
    ticks(50);
    check("win_state", int'(screen_state), 4);
    check("win_flag", int'(game_won), 1);
    check("win_wind", int'(show_wind), 0);
    check("win_progress", int'(progress), 0);
    buttonU = 1'b1;
    ticks(1);
    check("win_restart", int'(screen_state), 0);
    check("win_flag_clear", int'(game_won), 0);

    // Gravity decay down to the floor.
    do_reset();
    start_game();
    volume = 4'd5;
    ticks(2);
    volume = 4'd0;
    ticks(2);
    check("decay_start", int'(progress), 10);
    for (int k = 1; k <= 15; k++) begin
      ticks(1);
      check("decay", int'(progress), (k < 10) ? 10 - k : 0);
      check("decay_blow", int'(show_blow), 1);
      check("decay_wind", int'(show_wind), 0);
    end
    check("decay_state", int'(screen_state), 1);

    // Freeze with enable low, then async reset mid-TRANS.
    do_reset();
    start_game();
    volume = 4'd5;
    ticks(12);
    ticks(50);
    check("frz_stick", int'(screen_state), 2);
    volume = 4'd8;
    ticks(8);
    volume = 4'd0;
    ticks(2);
    check("frz_30", int'(progress), 30);
    enable_bbw = 1'b0;
    volume     = 4'd8;
    ticks(20);
    check("frz_hold", int'(progress), 30);
    check("frz_state", int'(screen_state), 2);
    enable_bbw = 1'b1;
    ticks(1);
    check("frz_resume", int'(progress), 34);
    ticks(10);
    check("frz_sat", int'(progress), 72);
    check("frz_trans", int'(screen_state), 5);
    ticks(10);
    game_reset_n = 1'b0;
    #1;
    check("async_rst_state", int'(screen_state), 0);
    check("async_rst_prog", int'(progress), 0);
    idle(1);
    game_reset_n = 1'b1;
    ticks(2);
    check("post_rst_instr", int'(screen_state), 0);

    // Stage timeout.
    do_reset();
    start_game();
    volume = 4'd0;
`ifdef BBW_TIMEOUT_EN
    ticks(749);
    check("to_before", int'(screen_state), 1);
    check("to_lost_low", int'(game_lost), 0);
    ticks(1);
    check("to_lose", int'(screen_state), 6);
    check("to_lost", int'(game_lost), 1);
    check("to_blow", int'(show_blow), 0);
    buttonU = 1'b0;
    ticks(1);
    buttonU = 1'b1;
    ticks(1);
    check("to_restart", int'(screen_state), 0);
    check("to_lost_clear", int'(game_lost), 0);
`else
    ticks(800);
    check("no_timeout", int'(screen_state), 1);
    check("no_timeout_prog", int'(progress), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
